// File: rtl/mc_alu.sv
// Multi-cycle integer ALU: single-cycle ADD/SUB/AND/OR, iterative unsigned
// shift-add multiply and restoring divide, one bit per clock.
module mc_alu #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic             alu_src,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] imm,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             ovf_exc,
   output logic             div_zero
);

   localparam logic [1:0] st_idle = 2'd0;
   localparam logic [1:0] st_mul  = 2'd1;
   localparam logic [1:0] st_div  = 2'd2;
   localparam logic [1:0] st_fin  = 2'd3;

   localparam logic [2:0] op_add = 3'b000;
   localparam logic [2:0] op_sub = 3'b001;
   localparam logic [2:0] op_and = 3'b010;
   localparam logic [2:0] op_or  = 3'b011;
   localparam logic [2:0] op_mul = 3'b100;
   localparam logic [2:0] op_div = 3'b101;

   localparam logic [CNT_W-1:0] cnt_last = CNT_W'(WIDTH - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] opnd_b;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;

   logic [WIDTH-1:0] b_sel;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_trial;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;

   assign b_sel     = alu_src ? imm : b;
   assign sum       = a + b_sel;
   assign diff      = a - b_sel;
   // Multiplier sits in acc_lo and shifts out LSB-first; the partial product
   // enters acc_hi and shifts down into the vacated acc_lo bits.
   assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
   assign div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd_b};

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      step_hi = acc_hi;
      step_lo = acc_lo;
      if (state == st_mul) begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      end else if (state == st_div) begin
         // Trial subtraction went negative when its top bit is set: restore.
         if (div_trial[WIDTH]) step_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
         else                  step_hi = div_trial[WIDTH-1:0];
         step_lo = {acc_lo[WIDTH-2:0], ~div_trial[WIDTH]};
      end
   end

   assign busy = (state == st_mul) || (state == st_div);
   assign done = (state == st_fin);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= st_idle;
         cnt       <= '0;
         opnd_b    <= '0;
         acc_hi    <= '0;
         acc_lo    <= '0;
         result_lo <= '0;
         result_hi <= '0;
         ovf_exc   <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         case (state)
            st_idle: begin
               if (start) begin
                  cnt       <= '0;
                  opnd_b    <= b_sel;
                  acc_hi    <= '0;
                  acc_lo    <= a;
                  result_hi <= '0;
                  ovf_exc   <= 1'b0;
                  div_zero  <= 1'b0;
                  state     <= st_fin;
                  case (op)
                     op_add: begin
                        result_lo <= sum;
                        ovf_exc   <= (a[WIDTH-1] == b_sel[WIDTH-1]) &&
                                     (sum[WIDTH-1] != a[WIDTH-1]);
                     end
                     op_sub: begin
                        result_lo <= diff;
                        ovf_exc   <= (a[WIDTH-1] != b_sel[WIDTH-1]) &&
                                     (diff[WIDTH-1] != a[WIDTH-1]);
                     end
                     op_and: result_lo <= a & b_sel;
                     op_or:  result_lo <= a | b_sel;
                     op_mul: begin
                        result_lo <= result_lo;
                        result_hi <= result_hi;
                        ovf_exc   <= ovf_exc;
                        div_zero  <= div_zero;
                        state     <= st_mul;
                     end
                     op_div: begin
                        if (b_sel == '0) begin
                           result_lo <= '1;
                           result_hi <= a;
                           div_zero  <= 1'b1;
                        end else begin
                           result_lo <= result_lo;
                           result_hi <= result_hi;
                           ovf_exc   <= ovf_exc;
                           div_zero  <= div_zero;
                           state     <= st_div;
                        end
                     end
                     default: result_lo <= '0;
                  endcase
               end
            end
            st_mul, st_div: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               cnt    <= cnt + 1'b1;
               if (cnt == cnt_last) begin
                  result_lo <= step_lo;
                  result_hi <= step_hi;
                  ovf_exc   <= 1'b0;
                  div_zero  <= 1'b0;
                  state     <= st_fin;
               end
            end
            default: state <= st_idle;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_alu.sv
// Self-checking bench for mc_alu (WIDTH=16): directed ops with a reference
// model feeding a scoreboard queue, latency/busy checks and a mid-op reset.
module tb_mc_alu;

   typedef struct {
      logic [15:0] lo;
      logic [15:0] hi;
      logic        ovf;
      logic        dz;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic        alu_src;
   logic [15:0] a, b, imm;
   logic        busy, done;
   logic [15:0] result_lo, result_hi;
   logic        ovf_exc, div_zero;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   mc_alu #(.WIDTH(16), .CNT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .alu_src(alu_src),
      .a(a), .b(b), .imm(imm), .busy(busy), .done(done),
      .result_lo(result_lo), .result_hi(result_hi),
      .ovf_exc(ovf_exc), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] o, input logic src,
                                  input logic [15:0] ai, input logic [15:0] bi,
                                  input logic [15:0] ii);
      exp_t        e;
      logic [15:0] bs;
      logic [31:0] p;
      bs = src ? ii : bi;
      e  = '{lo: 16'h0, hi: 16'h0, ovf: 1'b0, dz: 1'b0};
      case (o)
         3'd0: begin e.lo = ai + bs; e.ovf = (ai[15] == bs[15]) && (e.lo[15] != ai[15]); end
         3'd1: begin e.lo = ai - bs; e.ovf = (ai[15] != bs[15]) && (e.lo[15] != ai[15]); end
         3'd2: e.lo = ai & bs;
         3'd3: e.lo = ai | bs;
         3'd4: begin p = 32'(ai) * 32'(bs); e.lo = p[15:0]; e.hi = p[31:16]; end
         3'd5: begin
            if (bs == 16'h0) begin e.lo = 16'hFFFF; e.hi = ai; e.dz = 1'b1; end
            else begin e.lo = ai / bs; e.hi = ai % bs; end
         end
         default: ;
      endcase
      return e;
   endfunction

   // Entered and left at a falling edge with the DUT idle.
   task automatic run_op(input string tag, input logic [2:0] o, input logic src,
                         input logic [15:0] ai, input logic [15:0] bi, input logic [15:0] ii,
                         input int exp_lat, input bit poke);
      exp_t e;
      int   lat = 0;
      int   busy_n = 0;
      bit   got = 0;
      sb.push_back(model(o, src, ai, bi, ii));
      op = o; alu_src = src; a = ai; b = bi; imm = ii; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      op = 3'($urandom); alu_src = 1'($urandom);
      a = 16'($urandom); b = 16'($urandom); imm = 16'($urandom);
      for (int n = 1; n <= 40 && !got; n++) begin
         @(negedge clk);
         if (poke && n == 5) start = 1'b1;
         if (poke && n == 6) start = 1'b0;
         if (busy) busy_n++;
         if (done) begin got = 1; lat = n; end
      end
      start = 1'b0;
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " busy cycles"}, 64'(busy_n), 64'(exp_lat - 1));
      e = sb.pop_front();
      if (got) begin
         check({tag, " result_lo"}, 64'(result_lo), 64'(e.lo));
         check({tag, " result_hi"}, 64'(result_hi), 64'(e.hi));
         check({tag, " ovf_exc"}, 64'(ovf_exc), 64'(e.ovf));
         check({tag, " div_zero"}, 64'(div_zero), 64'(e.dz));
      end
      @(negedge clk);
      check({tag, " done one cycle"}, 64'({done, busy}), 64'(0));
   endtask

   initial begin
      int done_seen;
      rst_n = 1'b0; start = 1'b0; op = 3'd0; alu_src = 1'b0;
      a = 16'h0; b = 16'h0; imm = 16'h0;
      #12;
      check("reset outputs", {busy, done, ovf_exc, div_zero, result_lo, result_hi},
            64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add ovf",   3'd0, 1'b0, 16'h7FFF, 16'h0001, 16'h0000, 1, 0);
      run_op("sub imm",   3'd1, 1'b1, 16'h0005, 16'h1111, 16'hFFFF, 1, 0);
      run_op("and",       3'd2, 1'b0, 16'hF0F0, 16'h3C3C, 16'h0000, 1, 0);
      run_op("or imm",    3'd3, 1'b1, 16'hA000, 16'hFFFF, 16'h0505, 1, 0);
      run_op("rsvd 6",    3'd6, 1'b0, 16'h1234, 16'h5678, 16'h9ABC, 1, 0);
      run_op("rsvd 7",    3'd7, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 0);
      run_op("add neg",   3'd0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1, 0);
      run_op("sub ovf",   3'd1, 1'b0, 16'h8000, 16'h0001, 16'h0000, 1, 0);
      run_op("mul max",   3'd4, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 17, 0);
      run_op("mul imm",   3'd4, 1'b1, 16'h1234, 16'h0000, 16'h0ABC, 17, 0);
      run_op("div 100/7", 3'd5, 1'b0, 16'd100, 16'd7, 16'h0000, 17, 1);
      run_op("div big",   3'd5, 1'b0, 16'hFFFF, 16'h00FF, 16'h0000, 17, 0);
      run_op("div small", 3'd5, 1'b1, 16'h0003, 16'h0000, 16'h8001, 17, 0);
      run_op("div zero",  3'd5, 1'b0, 16'h1234, 16'h0000, 16'h0000, 1, 0);

      // MUL aborted by asynchronous reset partway through the iteration.
      op = 3'd4; alu_src = 1'b0; a = 16'h1234; b = 16'h0101; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("mul busy before abort", 64'(busy), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset outputs", {busy, done, ovf_exc, div_zero, result_lo, result_hi},
            64'(0));
      done_seen = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (done) done_seen++;
         if (n == 2) rst_n = 1'b1;
      end
      check("no done after abort", 64'(done_seen), 64'(0));
      run_op("add after reset", 3'd0, 1'b0, 16'd2, 16'd3, 16'h0000, 1, 0);
      check("scoreboard drained", 64'(sb.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (legal values 8..32).
REQ-002 SHALL have parameter CNT_W, default 5, iteration counter width, at least clog2(WIDTH)+1.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  accept request; sampled only in IDLE.
REQ-006 SHALL have port op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 DIV, 110/111 reserved.
REQ-007 SHALL have port alu_src  input  1  1: operand B = imm; 0: operand B = b.
REQ-008 SHALL have port a  input  WIDTH  operand A.
REQ-009 SHALL have port b  input  WIDTH  operand B, register source.
REQ-010 SHALL have port imm  input  WIDTH  operand B, pre-extended immediate.
REQ-011 SHALL have port busy  output  1  high while a MUL/DIV iteration is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-013 SHALL have port result_lo  output  WIDTH  sum/diff/logic result, product low half, or quotient.
REQ-014 SHALL have port result_hi  output  WIDTH  product high half or remainder; zero for other ops.
REQ-015 SHALL have port ovf_exc  output  1  signed overflow on ADD/SUB, else 0.
REQ-016 SHALL have port div_zero  output  1  DIV with operand B = 0.

Function
REQ-017 SHALL latch op, a and the selected operand B on the accepting edge; later input changes have no effect on the operation in flight.
REQ-018 SHALL implement FSM states IDLE, MUL, DIV, FIN; transitions: IDLE->FIN on start with ADD/SUB/AND/OR/reserved/DIV-by-zero; IDLE->MUL on start with MUL; IDLE->DIV on start with DIV and B!=0; MUL/DIV->FIN when counter reaches WIDTH; FIN->IDLE always.
REQ-019 SHALL assert done for exactly the cycle the FSM is in FIN; busy is high exactly in MUL and DIV.
REQ-020 SHALL ignore start while not in IDLE: no queuing, no error.
REQ-021 SHALL compute ADD/SUB modulo 2^WIDTH; result_hi = 0.
REQ-022 SHALL set ovf_exc = 1 when operand signs match (ADD) or differ (SUB) and the result sign differs from A's sign; ovf_exc = 0 for all other ops.
REQ-023 SHALL compute AND/OR bitwise with result_hi = 0.
REQ-024 SHALL compute MUL as an unsigned shift-add, one bit per cycle over WIDTH cycles, giving the full 2*WIDTH product {result_hi, result_lo}.
REQ-025 SHALL compute DIV as an unsigned restoring division, one bit per cycle over WIDTH cycles: result_lo = quotient, result_hi = remainder.
REQ-026 SHALL, for DIV with B = 0, skip iteration and set result_lo = all ones, result_hi = A, div_zero = 1.
REQ-027 SHALL set div_zero = 0 for every op except DIV-by-zero.
REQ-028 SHALL set result_lo = result_hi = 0 and both flags to 0 for reserved opcodes; done still pulses.
REQ-029 SHALL give the following latency from the accepting edge to done: ADD/SUB/AND/OR/reserved/DIV-by-zero = 1 cycle; MUL/DIV = WIDTH+1 cycles.
REQ-030 SHALL update result_lo, result_hi, ovf_exc and div_zero only on entry to FIN, and hold them until the next FIN; intermediate iteration values are never visible on the outputs.
REQ-031 SHALL accept a new start in the cycle after FIN, so back-to-back single-cycle ops complete every 2 cycles.

Reset
REQ-032 SHALL, on rst_n low, immediately force the FSM to IDLE and set busy = 0, done = 0, result_lo = 0, result_hi = 0, ovf_exc = 0, div_zero = 0, and all internal registers and counters to 0.
REQ-033 SHALL abort an in-flight MUL/DIV when reset is asserted mid-operation, with no done pulse.
REQ-034 SHALL accept start on the first rising edge after rst_n is released.

Verification (WIDTH=16)
REQ-035 SHALL cover: ADD a=0x7FFF, b=0x0001 -> done 1 cycle later, result_lo=0x8000, ovf_exc=1, result_hi=0.
REQ-036 SHALL cover: SUB alu_src=1, a=0x0005, imm=0xFFFF -> result_lo=0x0006, ovf_exc=0.
REQ-037 SHALL cover: MUL a=0xFFFF, b=0xFFFF -> busy for 16 cycles, done at cycle 17, {hi,lo}=0xFFFE_0001.
REQ-038 SHALL cover: DIV a=100, b=7 -> done at cycle 17, result_lo=14, result_hi=2; a second start pulsed while busy is ignored.
REQ-039 SHALL cover: DIV a=0x1234, b=0 -> done 1 cycle later, div_zero=1, result_lo=0xFFFF, result_hi=0x1234.
REQ-040 SHALL cover: MUL started, rst_n low at iteration 8 -> outputs 0 asynchronously, no done; after release, ADD 2+3 -> result_lo=5.
